// File: rtl/cia_bus_sequencer.sv
// Host-bus front end: synchronises the raw PHI2/CS/RW/ADDR/DATA pins, derives
// PHI2 edge strobes, qualifies register read/write accesses, drives the data
// bus output enable, measures the PHI2 period and flags a stalled PHI2.
module cia_bus_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int SETTLE_CLKS  = 3,
  parameter int TIMEOUT_CLKS = 255,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             phi2_pin,
  input  logic             cs_n_pin,
  input  logic             rw_pin,
  input  logic [3:0]       addr_pin,
  input  logic [7:0]       data_pin,
  output logic             phi2_up,
  output logic             phi2_dn,
  output logic             rd,
  output logic             we,
  output logic [3:0]       addr,
  output logic [7:0]       data_w,
  output logic             oe,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             clk_lost
);

  localparam int PIN_W  = 15;
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);
  localparam int SET_W  = $clog2(SETTLE_CLKS + 1);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);
  localparam logic [SET_W-1:0]  SET_DONE  = SET_W'(SETTLE_CLKS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    PHI1     = 2'd1,
    SETTLE   = 2'd2,
    ACTIVE   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0][PIN_W-1:0] sync_q, sync_d;
  logic [PIN_W-1:0]  pin_s;
  logic              phi2_s, cs_n_s, rw_s;
  logic [3:0]        addr_s;
  logic [7:0]        data_s;

  state_t            state_q, state_d;
  logic              phi2_q, phi2_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [SET_W-1:0]  set_q, set_d, settle_inc;
  logic              cs_q, cs_d, rw_q, rw_d;
  logic [3:0]        addr_q, addr_d;
  logic [7:0]        data_w_q, data_w_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              period_valid_q, period_valid_d;
  logic              seen_up_q, seen_up_d;
  logic              clk_lost_q, clk_lost_d;

  logic live, edge_s, up, dn, timeout, access;

  assign pin_s  = sync_q[SYNC_STAGES-1];
  assign phi2_s = pin_s[14];
  assign cs_n_s = pin_s[13];
  assign rw_s   = pin_s[12];
  assign addr_s = pin_s[11:8];
  assign data_s = pin_s[7:0];

  // Strobes are suppressed while waiting for PHI2 to be seen low; a timeout
  // can only fire on a clk without a PHI2 edge.
  assign live    = (state_q != WAIT_LOW);
  assign edge_s  = phi2_s ^ phi2_q;
  assign up      = live & phi2_s & ~phi2_q;
  assign dn      = live & ~phi2_s & phi2_q;
  assign timeout = live & ~edge_s & (edge_q >= TIMEOUT_V);
  assign access  = (state_q == ACTIVE) & ~timeout;

  assign settle_inc = set_q + SET_W'(1);

  assign phi2_up      = up;
  assign phi2_dn      = dn;
  assign rd           = access & cs_q & rw_q;
  assign we           = access & cs_q & ~rw_q;
  assign oe           = rd;
  assign addr         = (state_q == ACTIVE) ? addr_q : 4'd0;
  assign data_w       = (state_q == ACTIVE) ? data_w_q : 8'd0;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign clk_lost     = clk_lost_q;

  // Pin synchroniser chain plus the sync-fill counter that blocks the FSM
  // until the chain holds real pin samples after reset.
  always_comb begin
    sync_d[0] = {phi2_pin, cs_n_pin, rw_pin, addr_pin, data_pin};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    phi2_d = phi2_s;
    fill_d = (fill_q == FILL_DONE) ? fill_q : fill_q + FILL_W'(1);
  end

  // Access FSM: wait for PHI2 low, settle after the rising edge, then hold a
  // frozen access until the falling edge; a timeout aborts from any state.
  always_comb begin
    state_d  = state_q;
    set_d    = set_q;
    cs_d     = cs_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    data_w_d = data_w_q;
    case (state_q)
      WAIT_LOW: begin
        if ((fill_q == FILL_DONE) && !phi2_s) state_d = PHI1;
      end
      PHI1: begin
        if (up) begin
          state_d = SETTLE;
          set_d   = SET_W'(1);
        end
      end
      SETTLE: begin
        if (dn) begin
          state_d = PHI1;
        end else begin
          set_d = settle_inc;
          if (settle_inc >= SET_DONE) begin
            state_d  = ACTIVE;
            cs_d     = ~cs_n_s;
            rw_d     = rw_s;
            addr_d   = addr_s;
            data_w_d = data_s;
          end
        end
      end
      ACTIVE: begin
        // The falling-edge clk keeps the last pre-edge data sample.
        if (dn) state_d = PHI1;
        else    data_w_d = data_s;
      end
      default: state_d = WAIT_LOW;
    endcase
    if (timeout) state_d = WAIT_LOW;
  end

  // Edge watchdog, period measurement and the sticky lost-clock flag.
  always_comb begin
    edge_d         = edge_s ? '0 : ((edge_q == CNT_MAX) ? edge_q : edge_q + CNT_W'(1));
    per_cnt_d      = up ? CNT_W'(1) : ((per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_W'(1));
    period_d       = period_q;
    period_valid_d = period_valid_q;
    seen_up_d      = live ? (seen_up_q | up) : 1'b0;
    clk_lost_d     = clk_lost_q;
    if (up) begin
      clk_lost_d = 1'b0;
      if (seen_up_q) begin
        period_d       = per_cnt_q;
        period_valid_d = 1'b1;
      end
    end
    if (timeout) begin
      clk_lost_d     = 1'b1;
      period_valid_d = 1'b0;
    end
  end

  // All state registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync_q         <= '0;
      phi2_q         <= 1'b0;
      fill_q         <= '0;
      state_q        <= WAIT_LOW;
      set_q          <= '0;
      cs_q           <= 1'b0;
      rw_q           <= 1'b0;
      addr_q         <= '0;
      data_w_q       <= '0;
      edge_q         <= '0;
      per_cnt_q      <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      seen_up_q      <= 1'b0;
      clk_lost_q     <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      phi2_q         <= phi2_d;
      fill_q         <= fill_d;
      state_q        <= state_d;
      set_q          <= set_d;
      cs_q           <= cs_d;
      rw_q           <= rw_d;
      addr_q         <= addr_d;
      data_w_q       <= data_w_d;
      edge_q         <= edge_d;
      per_cnt_q      <= per_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      seen_up_q      <= seen_up_d;
      clk_lost_q     <= clk_lost_d;
    end
  end

endmodule

// File: tb/tb_cia_bus_sequencer.sv
// Bench for cia_bus_sequencer: directed scenarios plus randomized PHI2 traffic,
// every clk compared against a cycle-indexed reference model of the pin rules.
module tb_cia_bus_sequencer;

  localparam int SYNC   = 2;
  localparam int SETTLE = 3;
  localparam int TMO    = 255;

  logic       clk = 1'b0;
  logic       res_n;
  logic       phi2_pin, cs_n_pin, rw_pin;
  logic [3:0] addr_pin;
  logic [7:0] data_pin;
  logic       phi2_up, phi2_dn, rd, we, oe, period_valid, clk_lost;
  logic [3:0] addr;
  logic [7:0] data_w;
  logic [7:0] period;

  always #5 clk = ~clk;

  cia_bus_sequencer dut (
    .clk(clk), .res_n(res_n), .phi2_pin(phi2_pin), .cs_n_pin(cs_n_pin),
    .rw_pin(rw_pin), .addr_pin(addr_pin), .data_pin(data_pin),
    .phi2_up(phi2_up), .phi2_dn(phi2_dn), .rd(rd), .we(we), .addr(addr),
    .data_w(data_w), .oe(oe), .period(period), .period_valid(period_valid),
    .clk_lost(clk_lost)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, indexed by clk number k since reset release.
  logic [14:0] hist [0:SYNC];
  int   k, last_edge, last_up, up_cycle;
  bit   live, phase_on;
  logic lat_cs, lat_rw;
  logic [3:0] lat_addr;
  logic [7:0] prev_data, m_period;
  bit   m_pvalid, m_lost;

  // Observation counters for scenario-level checks.
  int up_cnt, dn_cnt, rd_cnt, we_cnt, oe_cnt;
  logic [7:0] dn_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h clk=%0d", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= SYNC; i++) hist[i] = '0;
    k = 0; last_edge = -1; last_up = -1; up_cycle = 0;
    live = 0; phase_on = 0;
    lat_cs = 0; lat_rw = 0; lat_addr = '0; prev_data = '0;
    m_period = '0; m_pvalid = 0; m_lost = 0;
  endtask

  task automatic clr_cnt();
    up_cnt = 0; dn_cnt = 0; rd_cnt = 0; we_cnt = 0; oe_cnt = 0; dn_data = '0;
  endtask

  // One clk: capture pins at the edge, then compare every output 2ns later.
  task automatic step();
    logic s, q, edge_b, up_e, dn_e, tmo, active, rd_e, we_e;
    int idle, age;
    @(posedge clk);
    for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {phi2_pin, cs_n_pin, rw_pin, addr_pin, data_pin};
    k++;
    #2;
    s      = hist[SYNC-1][14];
    q      = hist[SYNC][14];
    edge_b = (s != q);
    idle   = k - last_edge - 1;
    if (idle > 255) idle = 255;
    up_e   = live && s && !q;
    dn_e   = live && !s && q;
    tmo    = live && !edge_b && (idle >= TMO);
    age    = k - up_cycle;
    active = live && phase_on && (age >= SETTLE);
    rd_e   = active && !tmo && lat_cs && lat_rw;
    we_e   = active && !tmo && lat_cs && !lat_rw;

    chk("phi2_up", phi2_up, up_e);
    chk("phi2_dn", phi2_dn, dn_e);
    chk("rd", rd, rd_e);
    chk("we", we, we_e);
    chk("oe", oe, rd_e);
    chk("addr", addr, active ? lat_addr : 4'd0);
    chk("data_w", data_w, active ? prev_data : 8'd0);
    chk("period", period, m_period);
    chk("period_valid", period_valid, m_pvalid);
    chk("clk_lost", clk_lost, m_lost);

    if (phi2_up) up_cnt++;
    if (phi2_dn) begin dn_cnt++; dn_data = data_w; end
    if (rd) rd_cnt++;
    if (we) we_cnt++;
    if (oe) oe_cnt++;

    if (phase_on && !dn_e && !tmo && age == SETTLE - 1) begin
      lat_cs   = ~hist[SYNC-1][13];
      lat_rw   = hist[SYNC-1][12];
      lat_addr = hist[SYNC-1][11:8];
    end
    if (up_e) begin
      if (last_up >= 0) begin
        m_period = ((k - last_up) > 255) ? 8'd255 : 8'(k - last_up);
        m_pvalid = 1;
      end
      last_up = k; m_lost = 0; phase_on = 1; up_cycle = k;
    end
    if (dn_e) phase_on = 0;
    if (tmo) begin
      m_lost = 1; m_pvalid = 0; live = 0; phase_on = 0; last_up = -1;
    end else if (!live && k >= SYNC && !s) begin
      live = 1;
    end
    if (edge_b) last_edge = k;
    prev_data = hist[SYNC-1][7:0];
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic phase(input int hi, input int lo);
    phi2_pin = 1'b1; run(hi);
    phi2_pin = 1'b0; run(lo);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_up"}, phi2_up, 0);
    chk({tag, "_dn"}, phi2_dn, 0);
    chk({tag, "_rd"}, rd, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_oe"}, oe, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_data_w"}, data_w, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_pvalid"}, period_valid, 0);
    chk({tag, "_lost"}, clk_lost, 0);
  endtask

  initial begin
    res_n = 1'b0; phi2_pin = 0; cs_n_pin = 1; rw_pin = 1; addr_pin = '0; data_pin = '0;
    model_reset(); clr_cnt();
    #12;
    chk_zero_outputs("reset");
    @(posedge clk); #2;
    res_n = 1'b1;

    // Read at a 24-clk PHI2 period.
    cs_n_pin = 0; rw_pin = 1; addr_pin = 4'hD; data_pin = 8'h55;
    run(30);
    repeat (3) phase(12, 12);
    clr_cnt();
    phase(12, 12);
    chk("t1_rd_len", rd_cnt, 10);
    chk("t1_oe_len", oe_cnt, 10);
    chk("t1_period", period, 24);
    chk("t1_pvalid", period_valid, 1);

    // Write with data changing mid high phase.
    clr_cnt();
    rw_pin = 0; data_pin = 8'h81;
    phi2_pin = 1; run(8);
    data_pin = 8'h92; run(4);
    phi2_pin = 0; run(12);
    chk("t2_we_len", we_cnt, 10);
    chk("t2_oe", oe_cnt, 0);
    chk("t2_dataw_dn", dn_data, 8'h92);

    // PHI2 high shorter than the settle time.
    clr_cnt();
    rw_pin = 1;
    repeat (3) phase(2, 12);
    chk("t3_up", up_cnt, 3);
    chk("t3_dn", dn_cnt, 3);
    chk("t3_rd", rd_cnt + we_cnt + oe_cnt, 0);

    // Chip select released after the sample point.
    clr_cnt();
    cs_n_pin = 0; rw_pin = 1; addr_pin = 4'h3;
    phi2_pin = 1; run(7);
    cs_n_pin = 1; run(5);
    phi2_pin = 0; run(12);
    chk("t4_rd_len", rd_cnt, 10);

    // Randomized traffic.
    for (int p = 0; p < 40; p++) begin
      int h1, h2, lo;
      h1 = $urandom_range(1, 8); h2 = $urandom_range(0, 8); lo = $urandom_range(1, 16);
      cs_n_pin = $urandom_range(0, 1); rw_pin = $urandom_range(0, 1);
      addr_pin = 4'($urandom); data_pin = 8'($urandom);
      phi2_pin = 1; run(h1);
      cs_n_pin = $urandom_range(0, 1); rw_pin = $urandom_range(0, 1);
      addr_pin = 4'($urandom); data_pin = 8'($urandom);
      run(h2);
      phi2_pin = 0; run(lo);
    end

    // PHI2 stalled high, then resumes.
    cs_n_pin = 0; rw_pin = 1; addr_pin = 4'hD;
    phase(12, 12); phase(12, 12);
    clr_cnt();
    phi2_pin = 1; run(300);
    chk("t5_lost", clk_lost, 1);
    chk("t5_pvalid", period_valid, 0);
    chk("t5_rd", rd, 0);
    chk("t5_dn", dn_cnt, 0);
    phi2_pin = 0; run(12);
    phase(12, 12);
    chk("t5_lost_clr", clk_lost, 0);
    chk("t5_pvalid_1st", period_valid, 0);
    phase(12, 12);
    chk("t5_pvalid_2nd", period_valid, 1);
    chk("t5_period", period, 24);

    // Reset in the middle of a read.
    phi2_pin = 1; run(8);
    chk("t6_rd_before", rd, 1);
    #1 res_n = 1'b0;
    #1;
    chk_zero_outputs("t6_async");
    model_reset();
    repeat (2) @(posedge clk);
    #2 res_n = 1'b1;
    clr_cnt();
    run(20);
    chk("t6_no_up", up_cnt, 0);
    phi2_pin = 0; run(12);
    phase(12, 12);
    chk("t6_up_after_low", up_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
